lab7soc_hex_ctrl: RTL
=====================

Name: lab7soc_hex_ctrl

Overview:
Avalon-MM slave that drives NUM_DIGITS seven-segment hex digits from a memory-mapped nibble register, with on-chip hex-to-segment decode. Adds per-digit enable, per-digit blink from a prescaled blink timer, global blank, and atomic bit set/clear aliases so software can update one digit without read-modify-write. Sits on the lab7soc Avalon bus in place of a plain PIO; segment outputs go straight to the board HEX pins.

Parameters:
NUM_DIGITS, 4, number of digits driven; legal range 1..8.
BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 2.
SEG_ACTIVE_LOW, 1, 1 = a lit segment drives 0 (DE-series boards); 0 = a lit segment drives 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address of the register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data; combinational, zero wait states, read latency 0
hex_seg  out  7*NUM_DIGITS  segments; digit i occupies [7i+6:7i], bit order g f e d c b a (bit 6 down to bit 0)
nibble_out  out  4*NUM_DIGITS  raw DATA register contents, for debug

Behaviour:
- Reset is asynchronous on reset_n low and is the already-decided reset. Clock is clk.
- Reset values: DATA=0, ENABLE=all ones, BLINK=0, CTRL.blank=0, blink counter=0, phase=0. hex_seg shows "0" on every digit (active-low pattern 7'h40 per digit). nibble_out=0.
- Write is accepted when chipselect=1 and write_n=0. At most one register is written per cycle. Only the low W bits of writedata are used: W=4*NUM_DIGITS for DATA-class registers, NUM_DIGITS for mask registers. Upper bits are ignored.
- Register map:
  - 0 DATA: read/write.
  - 1 ENABLE: read/write.
  - 2 BLINK: read/write.
  - 3 CTRL: bit0 blank (read/write); bit1 phase (read-only); bit2 restart (write-1 strobe, reads 0).
  - 4 DATA_SET: write-only; DATA <= DATA | wd.
  - 5 DATA_CLR: write-only; DATA <= DATA & ~wd.
  - 6, 7: reserved.
  - Reads of 4..7 return 0. Writes to 6 and 7 have no effect.
- readdata is zero-extended to 32 bits and reflects register state in the same cycle, with no side effects on read.
- Blink timer:
  - The counter increments every cycle.
  - At count BLINK_DIV-1 it wraps to 0 and phase toggles.
  - A CTRL write with bit2=1 forces counter=0 and phase=0 on the next edge, overriding a same-cycle wrap.
- Digit i is lit when ENABLE[i] & ~blank & ~(BLINK[i] & phase).
- Lit digit: segment code = decode(DATA[4i+3:4i]), inverted when SEG_ACTIVE_LOW=1.
- Unlit digit: all segments off (7'h7F when active-low).
- Decode table, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- hex_seg is registered. A register write or phase toggle at edge N is visible on hex_seg after edge N+1 (one-cycle latency).
- nibble_out equals DATA with no extra latency.
- Reset asserted mid-blink: outputs return to reset values immediately, and the counter restarts from 0 after release.

Test Plan:
- Reset, NUM_DIGITS=4, SEG_ACTIVE_LOW=1 -> hex_seg=28'h8102040 (four "0" digits); read addr1 returns 0xF.
- Write DATA=0x0000BEEF -> two cycles later digits 3..0 show b,E,E,F = 7'h03,06,06,0E (active-low); read addr0 returns 0x0000BEEF.
- From DATA=0x1234: write DATA_SET=0x00C0, then DATA_CLR=0x0004 -> DATA reads 0x12F0, and nibble_out matches after each write.
- Set BLINK_DIV=4, BLINK=0x1, let 4 cycles elapse -> phase=1, digit0 reads 7'h7F while digits 1..3 are unchanged; after 4 more cycles digit0 is restored.
- Write CTRL=0x4 on the exact wrap cycle -> phase stays 0 and counter=0; then write CTRL=0x1 -> all digits 7'h7F one cycle later; write ENABLE=0x2 with blank=0 -> only digit1 lit.
- Write to addr6 with 0xFFFFFFFF -> no register changes, and reads of 4..7 return 0.

Source files
------------

// File: rtl/lab7soc_hex_ctrl_if.sv
// Avalon-MM slave bus bundle for lab7soc_hex_ctrl.
//   address    : word address of the register (8 words)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (only the low bits a register needs are used)
//   readdata   : read data, combinational, read latency 0
// master modport: the bus host (CPU / testbench); slave modport: the controller.
interface lab7soc_hex_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab7soc_hex_ctrl.sv
// Seven-segment hex display controller on the lab7soc Avalon-MM bus.
// Holds one nibble per digit, decodes it to segments on chip and adds
// per-digit enable, per-digit blink, global blank and atomic set/clear
// aliases on the nibble register.
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   hex_seg    : registered segments, digit i at [7i+6:7i], bit order gfedcba
//   nibble_out : raw DATA register, for debug
//
// Register map (word addresses):
//   0 DATA     r/w   one nibble per digit
//   1 ENABLE   r/w   per-digit enable
//   2 BLINK    r/w   per-digit blink select
//   3 CTRL     bit0 blank (r/w), bit1 phase (ro), bit2 restart (w1 strobe, reads 0)
//   4 DATA_SET wo    DATA <= DATA | wd
//   5 DATA_CLR wo    DATA <= DATA & ~wd
//   6,7        reserved, reads 0, writes ignored
module lab7soc_hex_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lab7soc_hex_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic [4*NUM_DIGITS-1:0] nibble_out
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int MW = NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_ENABLE   = 3'd1;
  localparam logic [2:0] A_BLINK    = 3'd2;
  localparam logic [2:0] A_CTRL     = 3'd3;
  localparam logic [2:0] A_DATA_SET = 3'd4;
  localparam logic [2:0] A_DATA_CLR = 3'd5;

  // Segment pattern of a dark digit and of a lit "0", in board polarity.
  localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  // Hex nibble to active-high gfedcba segment code.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      4'hF: code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  // Board-polarity segment pattern for one digit, dark when not lit.
  function automatic logic [6:0] digit_seg(input logic [3:0] nib, input logic lit);
    logic [6:0] code;
    code = seg_decode(nib);
    if (!lit) begin
      return SEG_OFF;
    end else if (SEG_ACTIVE_LOW) begin
      return ~code;
    end else begin
      return code;
    end
  endfunction

  // Register state
  logic [DW-1:0]   data_q,   data_d;
  logic [MW-1:0]   enable_q, enable_d;
  logic [MW-1:0]   blink_q,  blink_d;
  logic            blank_q,  blank_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            phase_q,  phase_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  logic            wr_s;
  logic            restart_s;
  logic [DW-1:0]   wd_data_s;
  logic [MW-1:0]   wd_mask_s;
  logic            unused_wd_s;

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign wd_data_s = bus.writedata[DW-1:0];
  assign wd_mask_s = bus.writedata[MW-1:0];
  // Bits above the register width are deliberately ignored.
  assign unused_wd_s = ^bus.writedata;
  assign restart_s = wr_s && (bus.address == A_CTRL) && bus.writedata[2];

  // Register write decode: at most one register changes per cycle.
  always_comb begin
    data_d   = data_q;
    enable_d = enable_q;
    blink_d  = blink_q;
    blank_d  = blank_q;
    if (wr_s) begin
      case (bus.address)
        A_DATA:     data_d   = wd_data_s;
        A_ENABLE:   enable_d = wd_mask_s;
        A_BLINK:    blink_d  = wd_mask_s;
        A_CTRL:     blank_d  = bus.writedata[0];
        A_DATA_SET: data_d   = data_q | wd_data_s;
        A_DATA_CLR: data_d   = data_q & ~wd_data_s;
        default: begin
          data_d   = data_q;
          enable_d = enable_q;
          blink_d  = blink_q;
          blank_d  = blank_q;
        end
      endcase
    end else begin
      data_d   = data_q;
      enable_d = enable_q;
      blink_d  = blink_q;
      blank_d  = blank_q;
    end
  end

  // Blink timer; a restart strobe wins over a same-cycle wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_s) begin
      cnt_d   = {CW{1'b0}};
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = {CW{1'b0}};
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
    end
  end

  // Segment image built from the current registers; registered below,
  // which gives the one-cycle latency from a register change to the pins.
  always_comb begin
    hex_d = {(7*NUM_DIGITS){1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = digit_seg(data_q[4*i +: 4],
                                  enable_q[i] & ~blank_q & ~(blink_q[i] & phase_q));
    end
  end

  // Combinational read mux, zero-extended, no read side effects.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      A_DATA:   bus.readdata = 32'(data_q);
      A_ENABLE: bus.readdata = 32'(enable_q);
      A_BLINK:  bus.readdata = 32'(blink_q);
      A_CTRL:   bus.readdata = {30'd0, phase_q, blank_q};
      default:  bus.readdata = 32'd0;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= {DW{1'b0}};
      enable_q <= {MW{1'b1}};
      blink_q  <= {MW{1'b0}};
      blank_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      phase_q  <= 1'b0;
      hex_q    <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      data_q   <= data_d;
      enable_q <= enable_d;
      blink_q  <= blink_d;
      blank_q  <= blank_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      hex_q    <= hex_d;
    end
  end

  assign hex_seg    = hex_q;
  assign nibble_out = data_q;

endmodule
